// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external single-read/single-write SRAM,
// with a registered output stage. Define SRAM_FIFO_BYPASS_EN to let a push into an empty FIFO skip the SRAM.
module sram_fifo_ctrl #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [DATA_WIDTH-1:0]         push_data,
  output logic                          pop_valid,
  input  logic                          pop_ready,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH+2)-1:0]    count,
  output logic                          sram_wr_en,
  output logic [$clog2(DEPTH)-1:0]      sram_write_address,
  output logic [DATA_WIDTH-1:0]         sram_new_data,
  output logic [$clog2(DEPTH)-1:0]      sram_read_address,
  input  logic [DATA_WIDTH-1:0]         sram_data_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+2);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           sram_count_q, sram_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;

  logic push_fire, pop_fire, load, bypass, wr_en;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high.
  // push_ready depends only on registered occupancy and flush; pop_valid/pop_data
  // come straight from the output register and hold while stalled.
  always_comb begin
    push_ready = (sram_count_q < DEPTH_C) & !flush;
    push_fire  = push_valid & push_ready;
    pop_fire   = out_valid_q & pop_ready;
    load       = (sram_count_q != '0) & (!out_valid_q | pop_fire) & !flush;
`ifdef SRAM_FIFO_BYPASS_EN
    bypass     = push_fire & (sram_count_q == '0) & (!out_valid_q | pop_fire);
`else
    bypass     = 1'b0;
`endif
    wr_en      = push_fire & !bypass;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sram_count_d = sram_count_q;
    out_valid_d  = out_valid_q;
    pop_data_d   = pop_data_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      sram_count_d = '0;
      out_valid_d  = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (load)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, load})
        2'b10:   sram_count_d = sram_count_q + CNT_ONE;
        2'b01:   sram_count_d = sram_count_q - CNT_ONE;
        default: sram_count_d = sram_count_q;
      endcase
      // load and bypass are exclusive: one needs SRAM data, the other an empty SRAM.
      if (load) begin
        out_valid_d = 1'b1;
        pop_data_d  = sram_data_in;
      end else if (bypass) begin
        out_valid_d = 1'b1;
        pop_data_d  = push_data;
      end else if (pop_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sram_count_q <= '0;
      out_valid_q  <= 1'b0;
      pop_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sram_count_q <= sram_count_d;
      out_valid_q  <= out_valid_d;
      pop_data_q   <= pop_data_d;
    end
  end

  always_comb begin
    pop_valid          = out_valid_q;
    pop_data           = pop_data_q;
    count              = CW'(sram_count_q) + CW'(out_valid_q);
    sram_wr_en         = wr_en;
    sram_write_address = wr_ptr_q;
    sram_new_data      = push_data;
    sram_read_address  = rd_ptr_q;
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: models the SRAM macro, and checks against a queue model of FIFO contents.
module tb_sram_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int W     = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+2);

  logic          clk, rst_n, flush;
  logic          push_valid, push_ready, pop_valid, pop_ready;
  logic [W-1:0]  push_data, pop_data;
  logic [CW-1:0] count;
  logic          sram_wr_en;
  logic [AW-1:0] sram_write_address, sram_read_address;
  logic [W-1:0]  sram_new_data, sram_data_in;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  exp_q [$];
  int            errors = 0;
  int            checks = 0;

  logic          g_push_fire, g_pop_fire, g_wr_en;
  logic [AW-1:0] g_wr_addr;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data;

  sram_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .sram_wr_en(sram_wr_en), .sram_write_address(sram_write_address),
    .sram_new_data(sram_new_data), .sram_read_address(sram_read_address),
    .sram_data_in(sram_data_in)
  );

  // clock / SRAM macro model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (sram_wr_en) mem[sram_write_address] <= sram_new_data;
  assign sram_data_in = mem[sram_read_address];

  // One clock cycle: apply inputs, check state against the model, account transfers.
  task automatic cycle(input logic pv, input logic [W-1:0] pd, input logic pr, input logic fl);
    logic pf, qf, exp_pr, exp_wr;
    logic [W-1:0] e;
    int n;
    push_valid = pv; push_data = pd; pop_ready = pr; flush = fl;
    #1;
    n = exp_q.size();
    checks++;
    if (int'(count) !== n) begin
      errors++; $display("FAIL count: got %0d exp %0d", count, n);
    end
    if (fl || n < DEPTH || n == DEPTH+1) begin
      exp_pr = !fl && (n < DEPTH);
      checks++;
      if (push_ready !== exp_pr) begin
        errors++; $display("FAIL push_ready: got %b exp %b (occ %0d)", push_ready, exp_pr, n);
      end
    end
    if (n == 0) begin
      checks++;
      if (pop_valid !== 1'b0) begin
        errors++; $display("FAIL pop_valid_empty: got %b exp 0", pop_valid);
      end
    end
    if (prev_stall) begin
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== prev_data) begin
        errors++; $display("FAIL stall_hold: got v=%b d=%0h exp v=1 d=%0h", pop_valid, pop_data, prev_data);
      end
    end
    pf = pv & push_ready;
    qf = pop_valid & pr;
`ifdef SRAM_FIFO_BYPASS_EN
    exp_wr = pf && !(n == 0 || (n == 1 && qf)) && !fl;
`else
    exp_wr = pf && !fl;
`endif
    checks++;
    if (sram_wr_en !== exp_wr) begin
      errors++; $display("FAIL sram_wr_en: got %b exp %b", sram_wr_en, exp_wr);
    end
    if (sram_wr_en === 1'b1) begin
      checks++;
      if (sram_new_data !== pd) begin
        errors++; $display("FAIL sram_new_data: got %0h exp %0h", sram_new_data, pd);
      end
    end
    if (qf) begin
      checks++;
      if (n == 0) begin
        errors++; $display("FAIL pop_on_empty: got data %0h exp no pop", pop_data);
      end else begin
        e = exp_q.pop_front();
        if (pop_data !== e) begin
          errors++; $display("FAIL pop_data: got %0h exp %0h", pop_data, e);
        end
      end
    end
    if (fl) exp_q.delete();
    else if (pf) exp_q.push_back(pd);
    prev_stall  = pop_valid && !pr && !fl;
    prev_data   = pop_data;
    g_push_fire = pf; g_pop_fire = qf;
    g_wr_en     = sram_wr_en; g_wr_addr = sram_write_address;
    @(posedge clk); #1;
  endtask

  task automatic drain(output int pops);
    int k;
    pops = 0; k = 0;
    while (exp_q.size() > 0 && k < 80) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      if (g_pop_fire) pops++;
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_timeout: got %0d left exp 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    #1;
    checks++;
    if (pop_valid !== 1'b0 || push_ready !== 1'b1 || count !== '0 || sram_wr_en !== 1'b0 || pop_data !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b r=%b c=%0d we=%b d=%0h exp v=0 r=1 c=0 we=0 d=0",
               pop_valid, push_ready, count, sram_wr_en, pop_data);
    end
  endtask

  task automatic test_single_push();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
`ifdef SRAM_FIFO_BYPASS_EN
    checks++;
    if (g_wr_en !== 1'b0) begin
      errors++; $display("FAIL bypass_no_write: got %b exp 0", g_wr_en);
    end
`else
    checks++;
    if (g_wr_en !== 1'b1 || g_wr_addr !== '0) begin
      errors++; $display("FAIL first_write: got we=%b a=%0d exp we=1 a=0", g_wr_en, g_wr_addr);
    end
    checks++;
    if (pop_valid !== 1'b0) begin
      errors++; $display("FAIL latency_cycle1: got %b exp 0", pop_valid);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
`endif
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 8'hA5) begin
      errors++; $display("FAIL first_pop_ready: got v=%b d=%0h exp v=1 d=a5", pop_valid, pop_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_fill();
    int pops;
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0);
      checks++;
      if (!g_push_fire) begin
        errors++; $display("FAIL fill_accept: got 0 exp 1 at push %0d", i);
      end
    end
    checks++;
    if (push_ready !== 1'b0 || int'(count) !== DEPTH+1) begin
      errors++; $display("FAIL full: got r=%b c=%0d exp r=0 c=%0d", push_ready, count, DEPTH+1);
    end
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    checks++;
    if (g_push_fire) begin
      errors++; $display("FAIL full_reject: got 1 exp 0");
    end
    drain(pops);
    checks++;
    if (pops != DEPTH+1) begin
      errors++; $display("FAIL fill_pops: got %0d exp %0d", pops, DEPTH+1);
    end
  endtask

  task automatic test_wrap();
    int pushed, popped, k;
    pushed = 0; popped = 0; k = 0;
    while ((pushed < 40 || exp_q.size() > 0) && k < 300) begin
      cycle(pushed < 40, W'($urandom_range(0, 255)), k[0] == 1'b0, 1'b0);
      if (g_push_fire) pushed++;
      if (g_pop_fire)  popped++;
      checks++;
      if (int'(count) > DEPTH+1) begin
        errors++; $display("FAIL wrap_bound: got %0d exp <= %0d", count, DEPTH+1);
      end
      k++;
    end
    checks++;
    if (pushed != 40 || popped != 40) begin
      errors++; $display("FAIL wrap_totals: got push=%0d pop=%0d exp 40/40", pushed, popped);
    end
  endtask

  task automatic test_back_to_back();
    int pops;
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, W'($urandom_range(0, 255)), 1'b1, 1'b0);
      checks++;
      if (!g_push_fire || !g_pop_fire || int'(count) !== 5) begin
        errors++; $display("FAIL steady: got push=%b pop=%b c=%0d exp 1 1 5", g_push_fire, g_pop_fire, count);
      end
    end
    drain(pops);
  endtask

  task automatic test_flush();
    logic [W-1:0] held;
    for (int i = 0; i < 9; i++) cycle(1'b1, W'(8'h50 + i), 1'b0, 1'b0);
    held = pop_data;
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    #1;
    checks++;
    if (count !== '0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got c=%0d v=%b r=%b exp 0 0 1", count, pop_valid, push_ready);
    end
    checks++;
    if (pop_data !== held) begin
      errors++; $display("FAIL flush_keeps_data: got %0h exp %0h", pop_data, held);
    end
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int pops;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, W'($urandom_range(0, 255)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    for (int i = 0; i < 30; i++)
      cycle(1'b1, W'($urandom_range(0, 255)), $urandom_range(0, 4) == 0, 1'b0);
    drain(pops);
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_random();
    for (int i = 0; i < 12; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    test_reset();
    test_single_push();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
